// File: rtl/lc3_fetch_prefetch.sv
// ---------------------------------------------------------------------------
// lc3_fetch_prefetch
//
// LC-3 fetch stage with an instruction prefetch queue. A fetch PC (fpc)
// issues at most one instruction-memory read per cycle, as long as the
// queue has room for every word already requested. Each returned word is
// queued with the PC it was fetched from. The consumer sees the queue head
// through a valid/ready handshake. A taken branch flushes everything and
// restarts fetching at the branch target.
//
// Parameters
//   ADDR_W   : PC / memory address width
//   DATA_W   : instruction width
//   DEPTH    : queue entries (power of 2, >= 2; >= 3 for one fetch per cycle)
//   RESET_PC : fetch PC after reset
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   enable_fetch in   0 suppresses new memory requests
//   br_taken     in   redirect + flush strobe
//   br_target    in   redirect address
//   Imem_rd      out  memory read request (combinational)
//   Imem_addr    out  memory read address (= fpc)
//   Imem_dout    in   memory read data, valid the cycle after Imem_rd
//   instr_valid  out  queue head valid
//   instr_ready  in   consumer accepts the head
//   instr        out  head instruction (0 when empty)
//   pc           out  head PC (0 when empty)
//   npc          out  head PC + 1 (0 when empty)
//   count        out  occupied queue entries
// ---------------------------------------------------------------------------
module lc3_fetch_prefetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h3000)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable_fetch,
  input  logic                         br_taken,
  input  logic [ADDR_W-1:0]            br_target,
  output logic                         Imem_rd,
  output logic [ADDR_W-1:0]            Imem_addr,
  input  logic [DATA_W-1:0]            Imem_dout,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [DATA_W-1:0]            instr,
  output logic [ADDR_W-1:0]            pc,
  output logic [ADDR_W-1:0]            npc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Fetch and in-flight tracking
  logic [ADDR_W-1:0] r_fpc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;

  // Circular queue
  logic [DATA_W-1:0] r_data  [DEPTH];
  logic [ADDR_W-1:0] r_pc_q  [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W:0]    w_credit;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [ADDR_W-1:0] w_head_pc;

  // Credit counts the word still in flight, so the queue can never be
  // asked to hold more than DEPTH entries. A pop in this cycle is not
  // counted as free space; that keeps the issue path off the consumer's
  // ready signal.
  assign w_credit = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
  assign w_issue  = reset & enable_fetch & ~br_taken &
                    (w_credit < (CNT_W+1)'(DEPTH));
  assign w_push   = r_inflight & ~br_taken;
  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid & instr_ready;

  // Fetch PC and in-flight request
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fpc         <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (br_taken) begin
      r_fpc      <= br_target;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_fpc         <= r_fpc + ADDR_W'(1);
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_fpc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (br_taken) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= Imem_dout;
      r_pc_q[r_wr_ptr] <= r_inflight_pc;
    end
  end

  assign w_head_pc   = r_pc_q[r_rd_ptr];

  assign Imem_rd     = w_issue;
  assign Imem_addr   = r_fpc;
  assign instr_valid = w_valid;
  assign count       = r_count;
  assign instr       = w_valid ? r_data[r_rd_ptr]         : '0;
  assign pc          = w_valid ? w_head_pc                : '0;
  assign npc         = w_valid ? (w_head_pc + ADDR_W'(1)) : '0;

  a_no_overflow : assert property (
    @(posedge clock) disable iff (!reset)
      !(w_push && (r_count == CNT_W'(DEPTH)))
  );

endmodule

// File: tb/tb_lc3_fetch_prefetch.sv
module tb_lc3_fetch_prefetch;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [15:0] KEY = 16'hA5A5;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable_fetch;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              Imem_rd;
  logic [ADDR_W-1:0] Imem_addr;
  logic [DATA_W-1:0] Imem_dout = '0;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] npc;
  logic [CNT_W-1:0]  count;

  lc3_fetch_prefetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(16'h3000)
  ) dut (
    .clock(clock), .reset(reset), .enable_fetch(enable_fetch),
    .br_taken(br_taken), .br_target(br_target),
    .Imem_rd(Imem_rd), .Imem_addr(Imem_addr), .Imem_dout(Imem_dout),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc(pc), .npc(npc), .count(count)
  );

  always #5 clock = ~clock;

  // Instruction memory: word content is address ^ KEY, one-cycle latency.
  always @(posedge clock) begin
    if (Imem_rd) Imem_dout <= Imem_addr ^ KEY;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Compare every output against one expected record; instr/npc follow from pc.
  task automatic chk_all(input string tag, input logic e_rd, input logic [15:0] e_addr,
                         input logic e_v, input logic [15:0] e_pc, input logic [2:0] e_cnt);
    logic [15:0] e_npc;
    logic [15:0] e_instr;
    e_npc   = e_v ? e_pc + 16'd1 : 16'd0;
    e_instr = e_v ? e_pc ^ KEY   : 16'd0;
    chk({tag, "_rd"},    32'(Imem_rd),     32'(e_rd));
    chk({tag, "_addr"},  32'(Imem_addr),   32'(e_addr));
    chk({tag, "_valid"}, 32'(instr_valid), 32'(e_v));
    chk({tag, "_pc"},    32'(pc),          32'(e_pc));
    chk({tag, "_npc"},   32'(npc),         32'(e_npc));
    chk({tag, "_instr"}, 32'(instr),       32'(e_instr));
    chk({tag, "_count"}, 32'(count),       32'(e_cnt));
  endtask

  typedef struct {
    logic        en;
    logic        br;
    logic [15:0] tgt;
    logic        rdy;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_v;
    logic [15:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic br, input logic [15:0] tgt,
                              input logic rdy, input logic e_rd, input logic [15:0] e_addr,
                              input logic e_v, input logic [15:0] e_pc, input logic [2:0] e_cnt);
    vec_t v;
    v.en = en; v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.e_rd = e_rd; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_del;
    logic [15:0] exp_pc;

    // Back-pressure from reset: 4 issues, queue fills to 4, then drains in order.
    //   en br tgt      rdy  rd  addr     v  pc       cnt
    add(1, 0, 16'h0,    0,   1, 16'h3000, 0, 16'h0,    0);
    add(1, 0, 16'h0,    0,   1, 16'h3001, 0, 16'h0,    0);
    add(1, 0, 16'h0,    0,   1, 16'h3002, 1, 16'h3000, 1);
    add(1, 0, 16'h0,    0,   1, 16'h3003, 1, 16'h3000, 2);
    add(1, 0, 16'h0,    0,   0, 16'h3004, 1, 16'h3000, 3);
    add(1, 0, 16'h0,    0,   0, 16'h3004, 1, 16'h3000, 4);
    add(1, 0, 16'h0,    0,   0, 16'h3004, 1, 16'h3000, 4);
    add(1, 0, 16'h0,    1,   0, 16'h3004, 1, 16'h3000, 4);
    add(1, 0, 16'h0,    1,   1, 16'h3004, 1, 16'h3001, 3);
    add(1, 0, 16'h0,    1,   1, 16'h3005, 1, 16'h3002, 2);
    add(1, 0, 16'h0,    1,   1, 16'h3006, 1, 16'h3003, 2);
    add(1, 0, 16'h0,    1,   1, 16'h3007, 1, 16'h3004, 2);
    // Build count=3 with a word in flight, then flush to 0x4100.
    add(1, 0, 16'h0,    0,   1, 16'h3008, 1, 16'h3005, 2);
    add(1, 1, 16'h4100, 0,   0, 16'h3009, 1, 16'h3005, 3);
    add(1, 0, 16'h0,    1,   1, 16'h4100, 0, 16'h0,    0);
    add(1, 0, 16'h0,    1,   1, 16'h4101, 0, 16'h0,    0);
    add(1, 0, 16'h0,    1,   1, 16'h4102, 1, 16'h4100, 1);
    // Stall 5 cycles with a word in flight; it is still queued and delivered.
    add(0, 0, 16'h0,    1,   0, 16'h4103, 1, 16'h4101, 1);
    add(0, 0, 16'h0,    1,   0, 16'h4103, 1, 16'h4102, 1);
    add(0, 0, 16'h0,    1,   0, 16'h4103, 0, 16'h0,    0);
    add(0, 0, 16'h0,    1,   0, 16'h4103, 0, 16'h0,    0);
    add(0, 0, 16'h0,    1,   0, 16'h4103, 0, 16'h0,    0);
    add(1, 0, 16'h0,    1,   1, 16'h4103, 0, 16'h0,    0);
    add(1, 0, 16'h0,    1,   1, 16'h4104, 0, 16'h0,    0);
    add(1, 0, 16'h0,    1,   1, 16'h4105, 1, 16'h4103, 1);

    reset = 1'b0; enable_fetch = 1'b1; br_taken = 1'b0; br_target = '0; instr_ready = 1'b0;
    step();
    step();
    chk_all("reset", 1'b0, 16'h3000, 1'b0, 16'h0, 3'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      enable_fetch = vecs[i].en;
      br_taken     = vecs[i].br;
      br_target    = vecs[i].tgt;
      instr_ready  = vecs[i].rdy;
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].e_rd, vecs[i].e_addr, vecs[i].e_v,
              vecs[i].e_pc, vecs[i].e_cnt);
      step();
    end

    // Address wrap: redirect to 0xFFFE and track deliveries through the wrap,
    // with an irregular ready pattern so the queue pointers wrap many times.
    enable_fetch = 1'b1; br_taken = 1'b1; br_target = 16'hFFFE; instr_ready = 1'b1;
    step();
    br_taken = 1'b0; br_target = '0;
    #1;
    chk("wrap_first_addr", 32'(Imem_addr), 32'hFFFE);
    chk("wrap_first_rd",   32'(Imem_rd),   32'h1);
    n_del  = 0;
    exp_pc = 16'hFFFE;
    for (int i = 0; i < 40; i++) begin
      instr_ready = ((i % 3) != 2);
      #1;
      if (instr_valid && instr_ready) begin
        chk($sformatf("wrap%0d_pc", n_del),    32'(pc),    32'(exp_pc));
        chk($sformatf("wrap%0d_npc", n_del),   32'(npc),   32'(16'(exp_pc + 16'd1)));
        chk($sformatf("wrap%0d_instr", n_del), 32'(instr), 32'(exp_pc ^ KEY));
        exp_pc = exp_pc + 16'd1;
        n_del++;
      end
      step();
    end
    chk("wrap_enough_deliveries", 32'(n_del >= 12), 32'h1);

    // Asynchronous reset with a full queue.
    instr_ready = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_rd",    32'(Imem_rd), 32'h0);
    #1;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 16'h3000, 1'b0, 16'h0, 3'd0);
    step();
    reset = 1'b1; instr_ready = 1'b1;
    #1;
    chk_all("restart0", 1'b1, 16'h3000, 1'b0, 16'h0, 3'd0);
    step();
    chk_all("restart1", 1'b1, 16'h3001, 1'b0, 16'h0, 3'd0);
    step();
    chk_all("restart2", 1'b1, 16'h3002, 1'b1, 16'h3000, 3'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
